// File: rtl/register_bank.sv
// register_bank: 31x32 architectural register file with hardwired r0,
// a write-back port, a link port for r31 and a committed-write counter.
module register_bank #(
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        link_we,
  input  logic [31:0] link_data,
  output logic [31:0] q_0,
  output logic [31:0] q_1,
  output logic [31:0] q_2,
  output logic [31:0] q_3,
  output logic [31:0] q_4,
  output logic [31:0] q_5,
  output logic [31:0] q_6,
  output logic [31:0] q_7,
  output logic [31:0] q_8,
  output logic [31:0] q_9,
  output logic [31:0] q_10,
  output logic [31:0] q_11,
  output logic [31:0] q_12,
  output logic [31:0] q_13,
  output logic [31:0] q_14,
  output logic [31:0] q_15,
  output logic [31:0] q_16,
  output logic [31:0] q_17,
  output logic [31:0] q_18,
  output logic [31:0] q_19,
  output logic [31:0] q_20,
  output logic [31:0] q_21,
  output logic [31:0] q_22,
  output logic [31:0] q_23,
  output logic [31:0] q_24,
  output logic [31:0] q_25,
  output logic [31:0] q_26,
  output logic [31:0] q_27,
  output logic [31:0] q_28,
  output logic [31:0] q_29,
  output logic [31:0] q_30,
  output logic [31:0] q_31,
  output logic [15:0] wr_count
);

  logic [31:0] r [1:31];
  logic        wb_hit;
  logic        link_hit;
  logic [1:0]  inc;

  // Qualify both ports; write-back to r31 shadows a same-cycle link write.
  always_comb begin
    wb_hit   = we && (waddr != 5'd0);
    link_hit = link_we && !(we && (waddr == 5'd31));
    inc      = {1'b0, wb_hit} + {1'b0, link_hit};
  end

  genvar i;
  for (i = 1; i < 32; i++) begin : g_reg
    localparam logic [31:0] RV =
      (i == 28) ? GP_INIT :
      (i == 29) ? SP_INIT : 32'h0;
    localparam bit LINK = (i == 31);
    logic sel;
    assign sel = wb_hit && (waddr == 5'(i));
    // One register: reset value, write-back, then link (r31 only).
    always_ff @(posedge clk) begin
      if (!rst_n)
        r[i] <= RV;
      else if (sel)
        r[i] <= wdata;
      else if (LINK && link_hit)
        r[i] <= link_data;
    end
  end

  // Committed-write counter, wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n)
      wr_count <= 16'h0;
    else
      wr_count <= wr_count + 16'(inc);
  end

  assign q_0  = 32'h0;
  assign q_1  = r[1];
  assign q_2  = r[2];
  assign q_3  = r[3];
  assign q_4  = r[4];
  assign q_5  = r[5];
  assign q_6  = r[6];
  assign q_7  = r[7];
  assign q_8  = r[8];
  assign q_9  = r[9];
  assign q_10 = r[10];
  assign q_11 = r[11];
  assign q_12 = r[12];
  assign q_13 = r[13];
  assign q_14 = r[14];
  assign q_15 = r[15];
  assign q_16 = r[16];
  assign q_17 = r[17];
  assign q_18 = r[18];
  assign q_19 = r[19];
  assign q_20 = r[20];
  assign q_21 = r[21];
  assign q_22 = r[22];
  assign q_23 = r[23];
  assign q_24 = r[24];
  assign q_25 = r[25];
  assign q_26 = r[26];
  assign q_27 = r[27];
  assign q_28 = r[28];
  assign q_29 = r[29];
  assign q_30 = r[30];
  assign q_31 = r[31];

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: vector table + scoreboard queue for register_bank,
// plus hand sequences for reset checks and counter wrap.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        link_we;
  logic [31:0] link_data;
  logic [31:0] q [32];
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_bank dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .link_we(link_we), .link_data(link_data),
    .q_0(q[0]),   .q_1(q[1]),   .q_2(q[2]),   .q_3(q[3]),
    .q_4(q[4]),   .q_5(q[5]),   .q_6(q[6]),   .q_7(q[7]),
    .q_8(q[8]),   .q_9(q[9]),   .q_10(q[10]), .q_11(q[11]),
    .q_12(q[12]), .q_13(q[13]), .q_14(q[14]), .q_15(q[15]),
    .q_16(q[16]), .q_17(q[17]), .q_18(q[18]), .q_19(q[19]),
    .q_20(q[20]), .q_21(q[21]), .q_22(q[22]), .q_23(q[23]),
    .q_24(q[24]), .q_25(q[25]), .q_26(q[26]), .q_27(q[27]),
    .q_28(q[28]), .q_29(q[29]), .q_30(q[30]), .q_31(q[31]),
    .wr_count(wr_count)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        link_we;
    logic [31:0] link_data;
    int          idx;
    logic [31:0] val;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] val;
    logic [15:0] cnt;
  } exp_t;

  vec_t tbl [12];
  exp_t sb [$];

  function automatic logic [31:0] rst_val(int i);
    if (i == 28) return 32'h0000_1800;
    if (i == 29) return 32'h0000_3FFC;
    return 32'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    link_we = 1'b0; link_data = 32'h0;
  endtask

  task automatic apply(vec_t v, string name);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; we = v.we; waddr = v.waddr; wdata = v.wdata;
    link_we = v.link_we; link_data = v.link_data;
    e.name = name; e.idx = v.idx; e.val = v.val; e.cnt = v.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    idle();
    e = sb.pop_front();
    chk({e.name, "_q"}, q[e.idx], e.val);
    chk({e.name, "_cnt"}, {16'h0, wr_count}, {16'h0, e.cnt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    logic [4:0]  la;
    logic [31:0] ld;
    idle();
    rst_n = 1'b0;
    #1;
    chk("q0_pre_reset", q[0], 32'h0);
    @(posedge clk);
    #1;
    chk("q0_in_reset", q[0], 32'h0);
    idle();
    for (int i = 0; i < 32; i++)
      chk($sformatf("reset_q%0d", i), q[i], rst_val(i));
    chk("reset_cnt", {16'h0, wr_count}, 32'h0);

    //        rst we addr  wdata          lwe ldata          idx val            cnt
    tbl[0]  = '{1, 1, 5,  32'hDEAD_BEEF, 0, 32'h0,         5,  32'hDEAD_BEEF, 1};
    tbl[1]  = '{1, 1, 0,  32'hFFFF_FFFF, 0, 32'h0,         0,  32'h0,         1};
    tbl[2]  = '{1, 1, 31, 32'h1111_1111, 1, 32'h0040_0008, 31, 32'h1111_1111, 2};
    tbl[3]  = '{1, 1, 7,  32'h1111_1111, 1, 32'h0040_0008, 31, 32'h0040_0008, 4};
    tbl[4]  = '{1, 0, 0,  32'h0,         0, 32'h0,         7,  32'h1111_1111, 4};
    tbl[5]  = '{1, 0, 0,  32'h0,         1, 32'h0000_0123, 31, 32'h0000_0123, 5};
    tbl[6]  = '{1, 0, 5,  32'h0BAD_0BAD, 0, 32'h0,         5,  32'hDEAD_BEEF, 5};
    tbl[7]  = '{1, 1, 29, 32'hAAAA_AAAA, 0, 32'h0,         29, 32'hAAAA_AAAA, 6};
    tbl[8]  = '{0, 1, 29, 32'h5555_5555, 1, 32'h0000_0777, 29, 32'h0000_3FFC, 0};
    tbl[9]  = '{1, 1, 28, 32'hCAFE_F00D, 0, 32'h0,         28, 32'hCAFE_F00D, 1};
    tbl[10] = '{1, 1, 1,  32'h0000_0001, 1, 32'h8000_0000, 1,  32'h0000_0001, 3};
    tbl[11] = '{0, 0, 0,  32'h0,         0, 32'h0,         28, 32'h0000_1800, 0};

    for (int k = 0; k < 12; k++) begin
      apply(tbl[k], $sformatf("vec%0d", k));
      if (k == 0)
        for (int i = 0; i < 32; i++)
          if (i != 5)
            chk($sformatf("vec0_other_q%0d", i), q[i], rst_val(i));
      if (k == 8) begin
        chk("rstprio_q31", q[31], 32'h0);
        chk("rstprio_q7", q[7], 32'h0);
      end
      if (k == 10)
        chk("dual_q31", q[31], 32'h8000_0000);
    end

    // Mid-stream reset clears every register regardless of history.
    for (int i = 0; i < 32; i++)
      chk($sformatf("midrst_q%0d", i), q[i], rst_val(i));

    // Counter wrap: 65536 committed writes from reset.
    do_reset();
    la = 5'd1;
    ld = 32'h0;
    for (int n = 0; n < 65536; n++) begin
      @(negedge clk);
      la = 5'($urandom_range(31, 1));
      ld = $urandom;
      rst_n = 1'b1; we = 1'b1; waddr = la; wdata = ld;
      link_we = 1'b0; link_data = 32'h0;
      @(posedge clk);
      #1;
      idle();
      if (n == 65534)
        chk("wrap_cnt_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    end
    chk("wrap_cnt_zero", {16'h0, wr_count}, 32'h0);
    chk("wrap_last_val", q[la], ld);
    chk("wrap_q0", q[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter: SP_INIT, default 32'h0000_3FFC, reset value of register 29 ($sp).
REQ-002 Parameter: GP_INIT, default 32'h0000_1800, reset value of register 28 ($gp).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: we  input  1  write-back port enable.
REQ-006 Port: waddr  input  5  write-back destination register index.
REQ-007 Port: wdata  input  32  write-back data.
REQ-008 Port: link_we  input  1  link-write enable (JAL/JALR return address to register 31).
REQ-009 Port: link_data  input  32  link address.
REQ-010 Port: q_0 … q_31  output  32 each  current contents of registers 0..31, driven directly from storage for the downstream read-select stage.
REQ-011 Port: wr_count  output  16  number of committed register writes since reset.

Function
REQ-012 Storage: 31 flops of 32 bits for registers 1..31; no storage for register 0.
REQ-013 q_0 constant 32'h0000_0000 at all times, including during reset.
REQ-014 Write: on rising edge with rst_n=1, we=1, waddr!=0 -> reg[waddr] <= wdata; new value visible on q_<waddr> in the following cycle (1-cycle latency); no combinational path from wdata to any q_*.
REQ-015 we=1 with waddr=0: no register changes; not a committed write; wr_count unchanged.
REQ-016 Link write: on rising edge with rst_n=1, link_we=1 -> reg[31] <= link_data.
REQ-017 Simultaneous we=1 and link_we=1, waddr!=31: both registers updated in the same edge; wr_count +2.
REQ-018 Simultaneous we=1, waddr=31, link_we=1: wdata wins (write-back from older instruction is overwritten by... no -- wdata has priority, fixed decision); reg[31] <= wdata; wr_count +1 only.
REQ-019 wr_count: +1 per committed write-back (we=1, waddr!=0), +1 per committed link write not overridden by REQ-018; wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-020 No write enables high: all registers and wr_count hold.
REQ-021 Any X/undefined on waddr while we=0 has no effect on state.

Reset
REQ-022 On rising edge with rst_n=0: registers 1..27, 30, 31 <= 32'h0; reg[28] <= GP_INIT; reg[29] <= SP_INIT; wr_count <= 0.
REQ-023 Reset has priority over we and link_we in the same edge; writes presented during reset are discarded and not counted.
REQ-024 Reset asserted mid-stream (after arbitrary writes) restores REQ-022 values on the next edge regardless of prior contents.
REQ-025 Before the first rising edge with rst_n=0, q_1..q_31 and wr_count are undefined; q_0 is 0.

Verification
REQ-026 Reset then idle: rst_n=0 one edge -> q_28=32'h0000_1800, q_29=32'h0000_3FFC, all other q_*=0, wr_count=0.
REQ-027 Write r5: we=1, waddr=5, wdata=32'hDEAD_BEEF one edge -> q_5=32'hDEAD_BEEF next cycle, no other q_* changed, wr_count=1.
REQ-028 Write r0: we=1, waddr=0, wdata=32'hFFFF_FFFF -> q_0 stays 0, wr_count unchanged.
REQ-029 Collision: we=1, waddr=31, wdata=32'h1111_1111, link_we=1, link_data=32'h0040_0008 same edge -> q_31=32'h1111_1111, wr_count +1; repeat with waddr=7 -> q_7=32'h1111_1111, q_31=32'h0040_0008, wr_count +2.
REQ-030 Reset priority: write r29=32'hAAAA_AAAA, then rst_n=0 with we=1, waddr=29, wdata=32'h5555_5555 -> q_29=32'h0000_3FFC, wr_count=0.
REQ-031 Counter wrap: 65536 committed writes (random waddr 1..31) from reset -> wr_count=16'h0000; last written value readable on its q_*.
